// File: rtl/hi_lo_mult_div.sv
// HI/LO multiply/divide unit: 32-cycle iterative shift-add multiply and restoring
// divide on operand magnitudes, with MTHI/MTLO writes accepted only while idle.
module hi_lo_mult_div (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_execute,
  input  logic [1:0]  op_execute,
  input  logic [31:0] src_A_ALU_execute,
  input  logic [31:0] src_B_ALU_execute,
  input  logic        hi_write_execute,
  input  logic        lo_write_execute,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI_output,
  output logic [31:0] LO_output
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic        r_is_div;
  logic        r_neg_res;
  logic        r_neg_rem;
  logic        r_b_zero;
  logic [31:0] r_dividend;
  logic [31:0] r_operand;
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  // Operand conditioning on the accepting cycle; op[0]=1 selects the unsigned forms
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  assign w_signed = ~op_execute[0];
  assign w_a_neg  = w_signed & src_A_ALU_execute[31];
  assign w_b_neg  = w_signed & src_B_ALU_execute[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - src_A_ALU_execute) : src_A_ALU_execute;
  assign w_b_mag  = w_b_neg ? (32'd0 - src_B_ALU_execute) : src_B_ALU_execute;

  // Multiply step: acc_lo holds the remaining multiplier bits, product shifts in from the top
  logic [32:0] w_mul_sum;
  logic [31:0] w_mul_hi;
  logic [31:0] w_mul_lo;

  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_operand} : 33'd0);
  assign w_mul_hi  = w_mul_sum[32:1];
  assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[31:1]};

  // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
  logic [32:0] w_div_shift;
  logic [32:0] w_div_diff;
  logic        w_div_ge;
  logic [31:0] w_div_hi;
  logic [31:0] w_div_lo;

  assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
  assign w_div_diff  = w_div_shift - {1'b0, r_operand};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_operand});
  assign w_div_hi    = w_div_ge ? w_div_diff[31:0] : w_div_shift[31:0];
  assign w_div_lo    = {r_acc_lo[30:0], w_div_ge};

  logic [31:0] w_step_hi;
  logic [31:0] w_step_lo;

  assign w_step_hi = r_is_div ? w_div_hi : w_mul_hi;
  assign w_step_lo = r_is_div ? w_div_lo : w_mul_lo;

  // Sign fix-up applied to the result of the final step
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_prod     = {w_step_hi, w_step_lo};
  assign w_prod_fix = r_neg_res ? (64'd0 - w_prod) : w_prod;
  assign w_quot_fix = r_neg_res ? (32'd0 - w_step_lo) : w_step_lo;
  assign w_rem_fix  = r_neg_rem ? (32'd0 - w_step_hi) : w_step_hi;
  assign w_res_hi   = r_is_div ? (r_b_zero ? r_dividend : w_rem_fix) : w_prod_fix[63:32];
  assign w_res_lo   = r_is_div ? (r_b_zero ? 32'hFFFF_FFFF : w_quot_fix) : w_prod_fix[31:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_count    <= 5'd0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_b_zero   <= 1'b0;
      r_dividend <= 32'd0;
      r_operand  <= 32'd0;
      r_acc_hi   <= 32'd0;
      r_acc_lo   <= 32'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start_execute) begin
          r_state    <= S_RUN;
          r_count    <= 5'd0;
          r_is_div   <= op_execute[1];
          r_neg_res  <= w_a_neg ^ w_b_neg;
          r_neg_rem  <= w_a_neg;
          r_b_zero   <= (src_B_ALU_execute == 32'd0);
          r_dividend <= src_A_ALU_execute;
          r_acc_hi   <= 32'd0;
          r_acc_lo   <= op_execute[1] ? w_a_mag : w_b_mag;
          r_operand  <= op_execute[1] ? w_b_mag : w_a_mag;
        end else begin
          if (hi_write_execute) r_hi <= src_A_ALU_execute;
          if (lo_write_execute) r_lo <= src_A_ALU_execute;
        end
      end else begin
        r_acc_hi <= w_step_hi;
        r_acc_lo <= w_step_lo;
        r_count  <= r_count + 5'd1;
        if (r_count == 5'd31) begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  assign HI_output = r_hi;
  assign LO_output = r_lo;

endmodule

// File: tb/tb_hi_lo_mult_div.sv
// Randomized scoreboard bench for hi_lo_mult_div: driver pushes arithmetic-model
// results, a monitor pops and compares on every done pulse.
module tb_hi_lo_mult_div;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_execute;
  logic [1:0]  op_execute;
  logic [31:0] src_A_ALU_execute;
  logic [31:0] src_B_ALU_execute;
  logic        hi_write_execute;
  logic        lo_write_execute;
  logic        busy;
  logic        done;
  logic [31:0] HI_output;
  logic [31:0] LO_output;

  hi_lo_mult_div dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_execute     (start_execute),
    .op_execute        (op_execute),
    .src_A_ALU_execute (src_A_ALU_execute),
    .src_B_ALU_execute (src_B_ALU_execute),
    .hi_write_execute  (hi_write_execute),
    .lo_write_execute  (lo_write_execute),
    .busy              (busy),
    .done              (done),
    .HI_output         (HI_output),
    .LO_output         (LO_output)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          done_cyc;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from arithmetic definitions: returns {HI, LO}
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, "_hi"}, HI_output, e.hi);
        check({e.tag, "_lo"}, LO_output, e.lo);
        check({e.tag, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
        $display("op %s: HI=0x%08h LO=0x%08h at cycle %0d", e.tag, HI_output, LO_output, cyc);
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic idle_inputs();
    start_execute     = 1'b0;
    op_execute        = 2'b00;
    src_A_ALU_execute = 32'd0;
    src_B_ALU_execute = 32'd0;
    hi_write_execute  = 1'b0;
    lo_write_execute  = 1'b0;
  endtask

  // One operation from IDLE; noise drives ignored starts/MT writes/operand changes during RUN
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mt, input logic noise, input string tag);
    logic [63:0] r;
    logic [31:0] hold_hi, hold_lo;
    int          n, bad_busy, bad_hold;
    exp_t        e;
    @(negedge clk);
    hold_hi = HI_output;
    hold_lo = LO_output;
    start_execute     = 1'b1;
    op_execute        = op;
    src_A_ALU_execute = a;
    src_B_ALU_execute = b;
    hi_write_execute  = mt;
    lo_write_execute  = mt;
    n = cyc;
    r = ref_model(op, a, b);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.done_cyc = n + 33;
    e.tag = tag;
    sb_q.push_back(e);
    bad_busy = 0;
    bad_hold = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) bad_busy++;
      if (HI_output !== hold_hi || LO_output !== hold_lo) bad_hold++;
      if (noise) begin
        start_execute     = 1'($urandom_range(0, 1));
        op_execute        = 2'($urandom_range(0, 3));
        src_A_ALU_execute = $urandom();
        src_B_ALU_execute = $urandom();
        hi_write_execute  = 1'($urandom_range(0, 1));
        lo_write_execute  = 1'($urandom_range(0, 1));
      end else begin
        idle_inputs();
      end
    end
    @(negedge clk);
    idle_inputs();
    check({tag, "_busy_window_bad_cycles"}, 32'(bad_busy), 32'd0);
    check({tag, "_hold_bad_cycles"}, 32'(bad_hold), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", HI_output, 32'd0);
    check("reset_lo", LO_output, 32'd0);
    reset_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b1, "mult_neg3x5");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, "mult_minxmin");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, "div_neg7by2");
    run_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b1, "divu_7by2");
    run_op(2'b10, 32'h0000_1234, 32'd0, 1'b0, 1'b1, "div_by_zero");
    run_op(2'b11, 32'h8765_4321, 32'd0, 1'b1, 1'b1, "divu_by_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, "div_overflow");

    // MTHI/MTLO together in IDLE
    @(negedge clk);
    hi_write_execute  = 1'b1;
    lo_write_execute  = 1'b1;
    src_A_ALU_execute = 32'hCAFE_F00D;
    @(negedge clk);
    idle_inputs();
    check("mt_both_hi", HI_output, 32'hCAFE_F00D);
    check("mt_both_lo", LO_output, 32'hCAFE_F00D);
    check("mt_both_busy", 32'(busy), 32'd0);
    check("mt_both_done", 32'(done), 32'd0);

    // MTLO alone leaves HI untouched
    lo_write_execute  = 1'b1;
    src_A_ALU_execute = 32'h1357_9BDF;
    @(negedge clk);
    idle_inputs();
    check("mtlo_hi", HI_output, 32'hCAFE_F00D);
    check("mtlo_lo", LO_output, 32'h1357_9BDF);

    // Start DIVU, ignored MULT+MTHI at RUN cycle 5, reset at RUN cycle 10
    @(negedge clk);
    start_execute     = 1'b1;
    op_execute        = 2'b11;
    src_A_ALU_execute = 32'd1000;
    src_B_ALU_execute = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == 5) begin
        start_execute     = 1'b1;
        op_execute        = 2'b00;
        hi_write_execute  = 1'b1;
        src_A_ALU_execute = 32'h5555_AAAA;
        src_B_ALU_execute = 32'd3;
      end
      if (k == 10) reset_n = 1'b0;
    end
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hi", HI_output, 32'd0);
    check("abort_lo", LO_output, 32'd0);
    repeat (40) @(negedge clk);

    // Reset beats start and MT writes in the same cycle
    run_op(2'b01, 32'd9, 32'd9, 1'b0, 1'b0, "multu_9x9");
    @(negedge clk);
    reset_n           = 1'b0;
    start_execute     = 1'b1;
    op_execute        = 2'b01;
    hi_write_execute  = 1'b1;
    lo_write_execute  = 1'b1;
    src_A_ALU_execute = 32'h0BAD_BEEF;
    src_B_ALU_execute = 32'd2;
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_hi", HI_output, 32'd0);
    check("rst_prio_lo", LO_output, 32'd0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 1'b1,
             $sformatf("rand%0d", i));
    end

    repeat (40) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hi_lo_mult_div.md
HI_LO_MULT_DIV -- requirements
Module: hi_lo_mult_div

Interface
- REQ-001: clk  in  1  sole clock; all state updates on rising edge.
- REQ-002: reset_n  in  1  reset, synchronous, active-low.
- REQ-003: start_execute  in  1  request to begin a multiply/divide this cycle.
- REQ-004: op_execute  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- REQ-005: src_A_ALU_execute  in  32  rs operand (multiplicand/dividend; MTHI/MTLO data).
- REQ-006: src_B_ALU_execute  in  32  rt operand (multiplier/divisor).
- REQ-007: hi_write_execute  in  1  MTHI: write src_A_ALU_execute into HI.
- REQ-008: lo_write_execute  in  1  MTLO: write src_A_ALU_execute into LO.
- REQ-009: busy  out  1  operation in progress; hazard unit stalls HI/LO consumers.
- REQ-010: done  out  1  one-cycle pulse; new HI/LO valid this cycle.
- REQ-011: HI_output  out  32  HI register.
- REQ-012: LO_output  out  32  LO register.

Function
- REQ-013: States: IDLE and RUN only, plus a 5-bit iteration counter.
- REQ-014: IDLE with start_execute=1 in cycle N: latch operands and op, counter=0, RUN from N+1.
- REQ-015: RUN increments counter each cycle; the 32nd RUN cycle (counter=31) writes HI/LO and returns to IDLE.
- REQ-016: busy=1 exactly in cycles N+1..N+32; busy=0 in IDLE.
- REQ-017: HI/LO new values and done=1 visible in cycle N+33; done=0 all other cycles.
- REQ-018: Multiply: 32-step shift-add on operand magnitudes; 64-bit product, HI=[63:32], LO=[31:0].
- REQ-019: MULT: operands are two's complement; product negated (64-bit) when operand signs differ. MULTU: unsigned.
- REQ-020: Divide: 32-step restoring division on magnitudes; LO=quotient, HI=remainder.
- REQ-021: DIV: quotient negated when signs differ; remainder takes dividend's sign (truncation toward zero). DIVU: unsigned.
- REQ-022: Divide by zero (DIV or DIVU): normal 32-cycle latency; HI=dividend as latched, LO=0xFFFFFFFF.
- REQ-023: DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- REQ-024: start_execute while busy=1 is ignored; the in-flight operation is unaffected.
- REQ-025: In IDLE without start: hi_write_execute writes HI, lo_write_execute writes LO at next edge, both in same cycle allowed; done stays 0.
- REQ-026: hi_write_execute/lo_write_execute while busy=1 are ignored.
- REQ-027: start_execute together with hi/lo_write_execute in IDLE: start wins, MT writes dropped.
- REQ-028: Operand inputs are sampled only on the accepting cycle; later changes have no effect.
- REQ-029: HI_output/LO_output hold their previous values throughout RUN until the final write.

Reset
- REQ-030: reset_n=0 at a rising edge: state=IDLE, counter=0, HI_output=0, LO_output=0, busy=0, done=0.
- REQ-031: Reset mid-RUN aborts the operation; no partial result is ever written to HI/LO.
- REQ-032: Reset has priority over start_execute and MT writes in the same cycle.

Verification
- REQ-033: MULTU 0xFFFFFFFF x 0xFFFFFFFF at cycle N -> busy high N+1..N+32; cycle N+33: done=1, HI=0xFFFFFFFE, LO=0x00000001.
- REQ-034: MULT 0xFFFFFFFD (-3) x 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- REQ-035: DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
- REQ-036: DIV 0x00001234 / 0 -> HI=0x00001234, LO=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- REQ-037: Start DIVU, then start MULT and hi_write_execute=1 at RUN cycle 5, then reset_n=0 at RUN cycle 10 -> MULT and MTHI ignored; next cycle busy=0, done=0, HI=LO=0; no done pulse follows.
- REQ-038: IDLE, hi_write_execute=lo_write_execute=1, src_A=0xCAFEF00D -> next cycle HI=LO=0xCAFEF00D, busy=0, done=0.
